// File: rtl/dl_pkg.sv
// Shared definitions for the delay-line reader/writer pair: FSM states and
// the default EDSAC-style line geometry.
package dl_pkg;

  localparam int DL_WORD_BITS      = 17;
  localparam int DL_GAP_BITS       = 1;
  localparam int DL_WORDS_PER_LINE = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPTURE,
    DONE
  } dl_state_e;

endpackage

// File: rtl/dl_position_counter.sv
// Tracks the bit/word position of a circulating delay-line stream.
// samp_* give the position of the bit being sampled this cycle, with frame_sync applied.
module dl_position_counter #(
  parameter int WORD_BITS      = 17,
  parameter int GAP_BITS       = 1,
  parameter int WORDS_PER_LINE = 32,
  parameter int ADDR_W         = $clog2(WORDS_PER_LINE),
  parameter int BIT_W          = $clog2(WORD_BITS + GAP_BITS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              frame_sync,
  output logic [BIT_W-1:0]  samp_bit,
  output logic [ADDR_W-1:0] samp_word,
  output logic [ADDR_W-1:0] pos_word
);

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_BITS + GAP_BITS - 1);
  localparam logic [ADDR_W-1:0] WORD_LAST = ADDR_W'(WORDS_PER_LINE - 1);

  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0] pos_word_q, pos_word_d;

  always_comb begin
    // A qualified frame_sync forces the sampled bit to word 0, bit 0.
    samp_bit   = (bit_en && frame_sync) ? '0 : bit_cnt_q;
    samp_word  = (bit_en && frame_sync) ? '0 : pos_word_q;
    bit_cnt_d  = bit_cnt_q;
    pos_word_d = pos_word_q;
    if (bit_en) begin
      if (samp_bit == BIT_LAST) begin
        bit_cnt_d  = '0;
        pos_word_d = (samp_word == WORD_LAST) ? '0 : samp_word + ADDR_W'(1);
      end else begin
        bit_cnt_d  = samp_bit + BIT_W'(1);
        pos_word_d = samp_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q  <= '0;
      pos_word_q <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      pos_word_q <= pos_word_d;
    end
  end

  assign pos_word = pos_word_q;

endmodule

// File: rtl/delay_line_reader.sv
// Delay-line reader: tracks stream position and deserialises one addressed word.
// Optional DLR_GAP_CHECK_EN adds a sticky gap_err output for nonzero gap bits.
//
//   state   | meaning
//   IDLE    | ready for a request
//   WAIT    | waiting for bit 0 of the addressed word
//   CAPTURE | shifting in data bits 1..WORD_BITS-1
//   DONE    | result ready; rd_valid pulses on the next clock
module delay_line_reader
  import dl_pkg::*;
#(
  parameter int WORD_BITS      = DL_WORD_BITS,
  parameter int GAP_BITS       = DL_GAP_BITS,
  parameter int WORDS_PER_LINE = DL_WORDS_PER_LINE,
  parameter int ADDR_W         = $clog2(WORDS_PER_LINE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_en,
  input  logic                 bit_in,
  input  logic                 frame_sync,
  input  logic                 req_valid,
  input  logic [ADDR_W-1:0]    req_addr,
  output logic                 req_ready,
  output logic                 rd_valid,
  output logic [WORD_BITS-1:0] rd_data,
  output logic                 rd_err,
  output logic [ADDR_W-1:0]    pos_word
`ifdef DLR_GAP_CHECK_EN
  ,output logic                gap_err
`endif
);

  localparam int BIT_W  = $clog2(WORD_BITS + GAP_BITS);
  localparam int CIDX_W = $clog2(WORD_BITS);
  localparam logic [CIDX_W-1:0] CIDX_LAST = CIDX_W'(WORD_BITS - 1);

  logic [BIT_W-1:0]  samp_bit;
  logic [ADDR_W-1:0] samp_word;

  dl_position_counter #(
    .WORD_BITS      (WORD_BITS),
    .GAP_BITS       (GAP_BITS),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .ADDR_W         (ADDR_W),
    .BIT_W          (BIT_W)
  ) u_pos (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .frame_sync (frame_sync),
    .samp_bit   (samp_bit),
    .samp_word  (samp_word),
    .pos_word   (pos_word)
  );

  dl_state_e            state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [CIDX_W-1:0]    idx_q, idx_d;
  logic [WORD_BITS-1:0] rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 rd_err_q, rd_err_d;
  logic                 err_q, err_d;
  logic                 req_ready_q, req_ready_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    idx_d       = idx_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    rd_err_d    = 1'b0;
    err_d       = err_q;
    req_ready_d = req_ready_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          addr_d      = req_addr;
          if (32'(req_addr) >= 32'(WORDS_PER_LINE)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bit_en && samp_word == addr_q && samp_bit == '0) begin
          rd_data_d    = '0;
          rd_data_d[0] = bit_in;
          idx_d        = CIDX_W'(1);
          state_d      = CAPTURE;
        end
      end
      CAPTURE: begin
        if (bit_en) begin
          // Resync mid-word means the partial word cannot be trusted.
          if (frame_sync) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            rd_data_d[idx_q] = bit_in;
            if (idx_q == CIDX_LAST) begin
              state_d = DONE;
            end else begin
              idx_d = idx_q + CIDX_W'(1);
            end
          end
        end
      end
      DONE: begin
        rd_valid_d = 1'b1;
        rd_err_d   = err_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      idx_q       <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      idx_q       <= idx_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_err_q    <= rd_err_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_err    = rd_err_q;

`ifdef DLR_GAP_CHECK_EN
  logic gap_err_q, gap_err_d;

  always_comb begin
    gap_err_d = gap_err_q;
    if (bit_en && bit_in && samp_bit >= BIT_W'(WORD_BITS)) gap_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) gap_err_q <= 1'b0;
    else     gap_err_q <= gap_err_d;
  end

  assign gap_err = gap_err_q;
`endif

endmodule

// File: tb/tb_delay_line_reader.sv
// Randomised and directed bench for delay_line_reader with a position/timeline
// reference model; gap_err checks are active when DLR_GAP_CHECK_EN is defined.
module tb_delay_line_reader;

  localparam int WB  = 17;
  localparam int MIN = 18;
  localparam int WPL = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bit_en = 1'b0, bit_in = 1'b0, frame_sync = 1'b0;
  logic        req_valid = 1'b0;
  logic [4:0]  req_addr = '0;
  logic        req_ready, rd_valid, rd_err;
  logic [16:0] rd_data;
  logic [4:0]  pos_word;
`ifdef DLR_GAP_CHECK_EN
  logic        gap_err, gap24;
`endif

  logic        r24 = 1'b1, rv24 = 1'b0;
  logic [4:0]  a24 = '0;
  logic        rdy24, v24, e24;
  logic [16:0] d24;
  logic [4:0]  pw24;

  always #5 clk = ~clk;

  delay_line_reader dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .bit_in(bit_in), .frame_sync(frame_sync),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err), .pos_word(pos_word)
`ifdef DLR_GAP_CHECK_EN
    , .gap_err(gap_err)
`endif
  );

  delay_line_reader #(.WORDS_PER_LINE(24), .ADDR_W(5)) dut24 (
    .clk(clk), .rst(r24), .bit_en(1'b0), .bit_in(1'b0), .frame_sync(1'b0),
    .req_valid(rv24), .req_addr(a24), .req_ready(rdy24),
    .rd_valid(v24), .rd_data(d24), .rd_err(e24), .pos_word(pw24)
`ifdef DLR_GAP_CHECK_EN
    , .gap_err(gap24)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: absolute stream position plus a timeline of request events.
  int          m_word, m_bit, m_phase, m_addr, m_k, m_fin, m_edge = 0;
  int          sw, sb, lin;
  logic [16:0] m_data, m_vdata;
  logic        m_errflag, m_err, m_valid, m_ready, m_gap, m_live = 1'b0, rb;

  always @(posedge clk) begin
    m_edge++;
    if (rst) begin
      m_word = 0; m_bit = 0; m_phase = 0; m_fin = -10; m_data = '0; m_vdata = '0;
      m_err = 1'b0; m_valid = 1'b0; m_ready = 1'b1; m_gap = 1'b0; m_live = 1'b1;
    end else if (m_live) begin
      rb = m_ready;
      sw = (bit_en && frame_sync) ? 0 : m_word;
      sb = (bit_en && frame_sync) ? 0 : m_bit;
      if (bit_en && sb >= WB && bit_in) m_gap = 1'b1;
      case (m_phase)
        0: if (req_valid && rb) begin
             m_ready = 1'b0;
             if (int'(req_addr) >= WPL) begin m_errflag = 1'b1; m_fin = m_edge; m_phase = 3; end
             else begin m_addr = int'(req_addr); m_phase = 1; end
           end
        1: if (bit_en && sw == m_addr && sb == 0) begin
             m_data = '0; m_data[0] = bit_in; m_k = 1; m_phase = 2;
           end
        2: if (bit_en) begin
             if (frame_sync) begin m_errflag = 1'b1; m_fin = m_edge; m_phase = 3; end
             else begin
               m_data[m_k] = bit_in; m_k++;
               if (m_k == WB) begin m_errflag = 1'b0; m_fin = m_edge; m_phase = 3; end
             end
           end
        default: ;
      endcase
      if (bit_en) begin
        lin = (sw * MIN + sb + 1) % (WPL * MIN);
        m_word = lin / MIN; m_bit = lin % MIN;
      end
      m_valid = (m_edge == m_fin + 1);
      if (m_valid) begin m_vdata = m_data; m_err = m_errflag; end
      if (m_phase == 3 && m_edge == m_fin + 2) begin m_phase = 0; m_ready = 1'b1; end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("rd_valid", 32'(rd_valid), 32'(m_valid));
      check("req_ready", 32'(req_ready), 32'(m_ready));
      check("pos_word", 32'(pos_word), 32'(m_word));
      if (m_valid) begin
        check("rd_data", 32'(rd_data), 32'(m_vdata));
        check("rd_err", 32'(rd_err), 32'(m_err));
      end
`ifdef DLR_GAP_CHECK_EN
      check("gap_err", 32'(gap_err), 32'(m_gap));
`endif
    end
  end

  // Bench-side writer: position of the next bit it will emit.
  logic [16:0] mem [WPL];
  int          wp_word = 0, wp_bit = 0;
  logic        sync_on = 1'b0, f_fs = 1'b0, f_gap = 1'b0, f_rst = 1'b0;
  logic        s_vld, s_rdy, s_err, s_gap = 1'b0;
  logic [16:0] s_dat;
  logic [4:0]  s_pw;

  task automatic step(input logic en, input logic rv, input logic [4:0] ra);
    @(negedge clk);
    s_vld = rd_valid; s_rdy = req_ready; s_pw = pos_word; s_dat = rd_data; s_err = rd_err;
`ifdef DLR_GAP_CHECK_EN
    s_gap = gap_err;
`endif
    rst = f_rst; bit_en = en; req_valid = rv; req_addr = ra;
    if (en) begin
      frame_sync = f_fs || (sync_on && wp_word == 0 && wp_bit == 0);
      bit_in = (wp_bit < WB) ? mem[wp_word][wp_bit] : f_gap;
    end else begin
      frame_sync = 1'($urandom);
      bit_in = 1'($urandom);
    end
    @(posedge clk);
    if (en) begin
      if (wp_bit == MIN - 1) begin wp_bit = 0; wp_word = (wp_word + 1) % WPL; end
      else wp_bit++;
    end
  endtask

  task automatic goto_pos(input int w, input int b);
    while (!(wp_word == w && wp_bit == b)) step(1'b1, 1'b0, 5'd0);
  endtask

  task automatic wait_valid(input int bound, output int cnt);
    cnt = 0;
    do begin
      step(1'b1, 1'b0, 5'd0);
      cnt++;
    end while (!s_vld && cnt < bound);
  endtask

  localparam int ALIGN_LAT = 3 * MIN + (WB - 1) + 2;
  localparam int MISS_LAT  = (WPL * MIN - 4) + (WB - 1) + 2;

  initial begin
    int cnt;
    for (int k = 0; k < WPL; k++) mem[k] = 17'(k * 1001);

    // Reset and a full circulation of strobes.
    f_rst = 1'b1; step(1'b0, 1'b0, 5'd0);
    f_rst = 1'b0; step(1'b0, 1'b0, 5'd0);
    check("rst_ready", 32'(s_rdy), 32'd1);
    check("rst_valid", 32'(s_vld), 32'd0);
    check("rst_pos", 32'(s_pw), 32'd0);
    check("rst_data", 32'(s_dat), 32'd0);
    check("rst_err", 32'(s_err), 32'd0);
    for (int i = 0; i < 575; i++) step(1'b1, 1'b0, 5'd0);
    step(1'b1, 1'b0, 5'd0);
    check("pos_575", 32'(s_pw), 32'd31);
    step(1'b0, 1'b0, 5'd0);
    check("pos_576", 32'(s_pw), 32'd0);

    // Aligned read of word 5 requested while at word 2.
    sync_on = 1'b1;
    goto_pos(2, 0);
    step(1'b1, 1'b1, 5'd5);
    check("align_accept", 32'(s_rdy), 32'd1);
    wait_valid(1500, cnt);
    check("align_seen", 32'(s_vld), 32'd1);
    check("align_data", 32'(s_dat), 32'd5005);
    check("align_err", 32'(s_err), 32'd0);
    check("align_lat", 32'(cnt), 32'(ALIGN_LAT));

    // Word 3 already passing at accept: wait a whole circulation.
    goto_pos(3, 4);
    step(1'b1, 1'b1, 5'd3);
    check("miss_accept", 32'(s_rdy), 32'd1);
    wait_valid(1500, cnt);
    check("miss_seen", 32'(s_vld), 32'd1);
    check("miss_data", 32'(s_dat), 32'd3003);
    check("miss_lat", 32'(cnt), 32'(MISS_LAT));
    step(1'b0, 1'b0, 5'd0);

    // Out-of-range address on a 24-word line.
    @(negedge clk) r24 = 1'b1;
    @(negedge clk) r24 = 1'b0;
    @(negedge clk);
    check("oor_ready0", 32'(rdy24), 32'd1);
    check("oor_pos0", 32'(pw24), 32'd0);
    rv24 = 1'b1; a24 = 5'd30;
    @(negedge clk) rv24 = 1'b0;
    check("oor_valid_n1", 32'(v24), 32'd0);
    check("oor_ready_n1", 32'(rdy24), 32'd0);
    @(negedge clk);
    check("oor_valid_n2", 32'(v24), 32'd1);
    check("oor_err_n2", 32'(e24), 32'd1);
    @(negedge clk);
    check("oor_valid_n3", 32'(v24), 32'd0);
    check("oor_ready_n3", 32'(rdy24), 32'd1);

    // frame_sync at bit 8 of the target word aborts the capture.
    goto_pos(4, 0);
    step(1'b1, 1'b1, 5'd6);
    check("abort_accept", 32'(s_rdy), 32'd1);
    goto_pos(6, 8);
    wp_word = 0; wp_bit = 0; f_fs = 1'b1;
    step(1'b1, 1'b0, 5'd0);
    f_fs = 1'b0;
    wait_valid(100, cnt);
    check("abort_seen", 32'(s_vld), 32'd1);
    check("abort_err", 32'(s_err), 32'd1);
    check("abort_part", 32'(s_dat), 32'h76);
    step(1'b1, 1'b0, 5'd0);
    check("abort_ready", 32'(s_rdy), 32'd1);

    // A 1 in the gap after word 7 while word 7 is being read.
    goto_pos(5, 0);
    step(1'b1, 1'b1, 5'd7);
    goto_pos(7, 17);
    f_gap = 1'b1;
    step(1'b1, 1'b0, 5'd0);
    f_gap = 1'b0;
    check("gap_pre_valid", 32'(s_vld), 32'd0);
    step(1'b1, 1'b0, 5'd0);
    check("gap_read_valid", 32'(s_vld), 32'd1);
    check("gap_read_data", 32'(s_dat), 32'd7007);
    check("gap_read_err", 32'(s_err), 32'd0);
`ifdef DLR_GAP_CHECK_EN
    check("gap_set", 32'(s_gap), 32'd1);
    for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 5'd0);
    check("gap_sticky", 32'(s_gap), 32'd1);
    f_rst = 1'b1; step(1'b1, 1'b0, 5'd0);
    f_rst = 1'b0; step(1'b1, 1'b0, 5'd0);
    check("gap_rst", 32'(s_gap), 32'd0);
`endif

    // Randomised traffic against the model.
    for (int k = 0; k < WPL; k++) mem[k] = 17'($urandom);
    for (int i = 0; i < 6000; i++) begin
      f_fs  = ($urandom % 700) == 0;
      f_gap = ($urandom % 60) == 0;
      f_rst = ($urandom % 1800) == 0;
      step(($urandom % 8) != 0, ($urandom % 3) == 0, 5'($urandom));
    end
    f_fs = 1'b0; f_gap = 1'b0; f_rst = 1'b0;
    step(1'b0, 1'b0, 5'd0);
    step(1'b0, 1'b0, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
